iir_opti_top: RTL and testbench

Two-section cascaded biquad (SOS, direct form I) IIR filter for a 2048-sample signed 24-bit stream. It is the top of the filter datapath: a `start` pulse arms a run, samples stream in at up to one per clock, and filtered samples stream out with an output index. When all 2048 outputs are produced the block flags completion; it also flags when the output has settled.

---
 rtl/opti_pkg.sv | 40 ++++
 rtl/opti_sos.sv | 61 ++++++
 rtl/iir_opti_top.sv | 122 ++++++++++++
 tb/tb_iir_opti_top.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/opti_pkg.sv
// Shared widths, default coefficients and the round/saturate helper for the
// two-section direct-form-I biquad datapath.
package opti_pkg;
  localparam int DATA_W     = 24;
  localparam int COEF_W     = 24;
  localparam int PROD_W     = 48;
  localparam int ACC_W      = 51;
  localparam int FRAC_SHIFT = 22;
  localparam int N_SECT     = 2;
  localparam int N_COEF     = 5;
  localparam int SECT_W     = N_COEF * COEF_W;
  localparam int COEFS_W    = N_SECT * SECT_W;
  localparam int N_SAMPLES  = 2048;
  localparam int ADDR_W     = $clog2(N_SAMPLES);
  localparam int Q_W        = ACC_W - FRAC_SHIFT;

  localparam logic [ACC_W-1:0] ROUND_BIAS = 51'h200000;

  // Unity-DC-gain low-pass, double pole at 0.75 per section; MSB-first order
  // is {s1: a2,a1,b2,b1,b0, s0: a2,a1,b2,b1,b0}.
  localparam logic [COEFS_W-1:0] OPTI_COEFS = {
    24'h240000, 24'hA00000, 24'h010000, 24'h020000, 24'h010000,
    24'h240000, 24'hA00000, 24'h010000, 24'h020000, 24'h010000
  };

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_RUN = 1'b1} state_e;

  function automatic logic [DATA_W-1:0] round_sat(input logic [ACC_W-1:0] acc);
    logic [ACC_W-1:0] rnd;
    logic [Q_W-1:0]   q;
    rnd = acc + ROUND_BIAS;
    q   = rnd[ACC_W-1:FRAC_SHIFT];
    if (!q[Q_W-1] && (|q[Q_W-2:DATA_W-1]))
      round_sat = {1'b0, {(DATA_W-1){1'b1}}};
    else if (q[Q_W-1] && !(&q[Q_W-2:DATA_W-1]))
      round_sat = {1'b1, {(DATA_W-1){1'b0}}};
    else
      round_sat = q[DATA_W-1:0];
  endfunction
endpackage

// File: rtl/opti_sos.sv
// One direct-form-I biquad section; the registered y1 doubles as the section
// output so the feedback path stays a single combinational cycle.
module opti_sos
  import opti_pkg::*;
#(
  parameter logic [SECT_W-1:0] COEFS = OPTI_COEFS[0 +: SECT_W]
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr_i,
  input  logic              valid_i,
  input  logic [DATA_W-1:0] x_i,
  output logic              valid_o,
  output logic [DATA_W-1:0] y_o
);
  localparam logic signed [COEF_W-1:0] B0 = COEFS[0*COEF_W +: COEF_W];
  localparam logic signed [COEF_W-1:0] B1 = COEFS[1*COEF_W +: COEF_W];
  localparam logic signed [COEF_W-1:0] B2 = COEFS[2*COEF_W +: COEF_W];
  localparam logic signed [COEF_W-1:0] A1 = COEFS[3*COEF_W +: COEF_W];
  localparam logic signed [COEF_W-1:0] A2 = COEFS[4*COEF_W +: COEF_W];

  logic signed [DATA_W-1:0] x0_s;
  logic signed [DATA_W-1:0] x1_q, x2_q, y1_q, y2_q;
  logic                     valid_q;
  logic signed [PROD_W-1:0] mul_b0_x, mul_b1_x, mul_b2_x, mul_a1_y, mul_a2_y;
  logic signed [ACC_W-1:0]  acc_s;
  logic        [DATA_W-1:0] y_d;

  assign x0_s     = x_i;
  assign mul_b0_x = PROD_W'(B0) * PROD_W'(x0_s);
  assign mul_b1_x = PROD_W'(B1) * PROD_W'(x1_q);
  assign mul_b2_x = PROD_W'(B2) * PROD_W'(x2_q);
  assign mul_a1_y = PROD_W'(A1) * PROD_W'(y1_q);
  assign mul_a2_y = PROD_W'(A2) * PROD_W'(y2_q);

  assign acc_s = ACC_W'(mul_b0_x) + ACC_W'(mul_b1_x) + ACC_W'(mul_b2_x)
               - ACC_W'(mul_a1_y) - ACC_W'(mul_a2_y);
  assign y_d   = round_sat(acc_s);

  // Delay lines only move on valid samples so input gaps leave state intact.
  always_ff @(posedge clk) begin
    if (rst_n || clr_i) begin
      x1_q    <= '0;
      x2_q    <= '0;
      y1_q    <= '0;
      y2_q    <= '0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= valid_i;
      if (valid_i) begin
        x1_q <= x0_s;
        x2_q <= x1_q;
        y1_q <= y_d;
        y2_q <= y1_q;
      end
    end
  end

  assign valid_o = valid_q;
  assign y_o     = y1_q;
endmodule

// File: rtl/iir_opti_top.sv
// Two cascaded biquads with run control, output indexing, completion pulse and
// output-settled detection. rst_n is an active-high synchronous reset.
module iir_opti_top
  import opti_pkg::*;
#(
  parameter logic [COEFS_W-1:0] COEFS         = OPTI_COEFS,
  parameter logic [DATA_W-1:0]  STABLE_THRESH = 24'd64,
  parameter int                 STABLE_LEN    = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [DATA_W-1:0] data_in,
  input  logic              data_in_valid,
  output logic [DATA_W-1:0] data_out,
  output logic              data_out_valid,
  output logic [ADDR_W-1:0] addr,
  output logic              filter_done,
  output logic              stable_out
);
  localparam int CNT_W = $clog2(STABLE_LEN + 1);

  state_e              state_q;
  logic                in_valid_q;
  logic [DATA_W-1:0]   in_data_q;
  logic                s0_valid, s1_valid;
  logic [DATA_W-1:0]   s0_y, s1_y;
  logic                accept_s, last_s, settled_s;
  logic signed [DATA_W:0] step_s;
  logic [DATA_W:0]     step_abs_s;
  logic [ADDR_W-1:0]   idx_q, addr_q;
  logic [DATA_W-1:0]   data_out_q, prev_y_q;
  logic                data_out_valid_q, filter_done_q, stable_q;
  logic [CNT_W-1:0]    stab_cnt_q, stab_cnt_d;

  assign accept_s = (state_q == ST_RUN) && data_in_valid && !start;

  // Input register; a sample arriving with start is dropped.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      in_valid_q <= 1'b0;
      in_data_q  <= '0;
    end else if (start) begin
      in_valid_q <= 1'b0;
    end else begin
      in_valid_q <= accept_s;
      if (accept_s) in_data_q <= data_in;
    end
  end

  opti_sos #(.COEFS(COEFS[0 +: SECT_W])) u_sos0 (
    .clk(clk), .rst_n(rst_n), .clr_i(start),
    .valid_i(in_valid_q), .x_i(in_data_q), .valid_o(s0_valid), .y_o(s0_y)
  );

  opti_sos #(.COEFS(COEFS[SECT_W +: SECT_W])) u_sos1 (
    .clk(clk), .rst_n(rst_n), .clr_i(start),
    .valid_i(s0_valid), .x_i(s0_y), .valid_o(s1_valid), .y_o(s1_y)
  );

  assign last_s     = s1_valid && (idx_q == ADDR_W'(N_SAMPLES - 1));
  assign step_s     = $signed({s1_y[DATA_W-1], s1_y}) - $signed({prev_y_q[DATA_W-1], prev_y_q});
  assign step_abs_s = step_s[DATA_W] ? -step_s : step_s;
  assign settled_s  = step_abs_s <= {1'b0, STABLE_THRESH};

  // Settle counter saturates at STABLE_LEN; any large step restarts it.
  always_comb begin
    stab_cnt_d = stab_cnt_q;
    if (!settled_s)
      stab_cnt_d = '0;
    else if (stab_cnt_q != CNT_W'(STABLE_LEN))
      stab_cnt_d = stab_cnt_q + CNT_W'(1);
    else
      stab_cnt_d = stab_cnt_q;
  end

  // Run FSM and registered output stage.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_q          <= ST_IDLE;
      idx_q            <= '0;
      addr_q           <= '0;
      data_out_q       <= '0;
      data_out_valid_q <= 1'b0;
      filter_done_q    <= 1'b0;
      prev_y_q         <= '0;
      stab_cnt_q       <= '0;
      stable_q         <= 1'b0;
    end else if (start) begin
      state_q          <= ST_RUN;
      idx_q            <= '0;
      addr_q           <= '0;
      data_out_valid_q <= 1'b0;
      filter_done_q    <= 1'b0;
      prev_y_q         <= '0;
      stab_cnt_q       <= '0;
      stable_q         <= 1'b0;
    end else begin
      data_out_valid_q <= s1_valid;
      filter_done_q    <= last_s;
      if (s1_valid) begin
        data_out_q <= s1_y;
        prev_y_q   <= s1_y;
        addr_q     <= idx_q;
        idx_q      <= idx_q + ADDR_W'(1);
        stab_cnt_q <= stab_cnt_d;
        stable_q   <= (stab_cnt_d == CNT_W'(STABLE_LEN));
      end
      case (state_q)
        ST_IDLE: state_q <= ST_IDLE;
        ST_RUN:  if (last_s) state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign data_out       = data_out_q;
  assign data_out_valid = data_out_valid_q;
  assign addr           = addr_q;
  assign filter_done    = filter_done_q;
  assign stable_out     = stable_q;
endmodule

// File: tb/tb_iir_opti_top.sv
// Scoreboard bench: three filter instances (passthrough, one-pole impulse,
// saturating gain) share stimulus; the selected one is checked against a queue.
module tb_iir_opti_top;
  import opti_pkg::*;

  localparam logic [COEFS_W-1:0] PASS_C = {
    24'h000000, 24'h000000, 24'h000000, 24'h000000, 24'h400000,
    24'h000000, 24'h000000, 24'h000000, 24'h000000, 24'h400000};
  localparam logic [COEFS_W-1:0] IMP_C = {
    24'h000000, 24'h000000, 24'h000000, 24'h000000, 24'h400000,
    24'h000000, 24'hE00000, 24'h000000, 24'h000000, 24'h400000};
  localparam logic [COEFS_W-1:0] SAT_C = {
    24'h000000, 24'h000000, 24'h000000, 24'h000000, 24'h7FFFFF,
    24'h000000, 24'h000000, 24'h000000, 24'h000000, 24'h7FFFFF};

  typedef struct {
    logic [23:0] data;
    logic [10:0] addr;
    logic        done;
    logic        stable;
    int          acc_cyc;
  } exp_t;

  typedef struct {
    logic [23:0] din;
    logic [23:0] dexp;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n, start, din_v;
  logic [23:0] din;
  logic [23:0] d_out [3];
  logic        d_v   [3];
  logic [10:0] a     [3];
  logic        done  [3];
  logic        stab  [3];

  exp_t        sb[$];
  vec_t        sat_tab[5];
  int          sel = 0;
  int          checks = 0, errors = 0;
  int          cyc = 0;
  int          done_seen = 0, valid_seen = 0, first_stable = -1;
  int          m_addr = 0, m_cnt = 0;
  logic [23:0] m_prev = 24'h0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  iir_opti_top #(.COEFS(PASS_C)) u_pass (
    .clk(clk), .rst_n(rst_n), .start(start), .data_in(din), .data_in_valid(din_v),
    .data_out(d_out[0]), .data_out_valid(d_v[0]), .addr(a[0]),
    .filter_done(done[0]), .stable_out(stab[0]));
  iir_opti_top #(.COEFS(IMP_C)) u_imp (
    .clk(clk), .rst_n(rst_n), .start(start), .data_in(din), .data_in_valid(din_v),
    .data_out(d_out[1]), .data_out_valid(d_v[1]), .addr(a[1]),
    .filter_done(done[1]), .stable_out(stab[1]));
  iir_opti_top #(.COEFS(SAT_C)) u_sat (
    .clk(clk), .rst_n(rst_n), .start(start), .data_in(din), .data_in_valid(din_v),
    .data_out(d_out[2]), .data_out_valid(d_v[2]), .addr(a[2]),
    .filter_done(done[2]), .stable_out(stab[2]));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Reference: addr/done/stable derived from the expected output sequence.
  task automatic push_exp(input logic [23:0] y);
    exp_t e;
    int   st;
    st = int'($signed(y)) - int'($signed(m_prev));
    if (st < 0) st = -st;
    if (st <= 64) begin
      if (m_cnt < 16) m_cnt++;
    end else begin
      m_cnt = 0;
    end
    e.data    = y;
    e.addr    = 11'(m_addr);
    e.done    = (m_addr == 2047);
    e.stable  = (m_cnt == 16);
    e.acc_cyc = cyc + 1;
    sb.push_back(e);
    m_prev = y;
    m_addr = (m_addr + 1) % 2048;
  endtask

  task automatic model_clear();
    m_addr = 0;
    m_cnt  = 0;
    m_prev = 24'h0;
  endtask

  task automatic do_start(input logic with_sample);
    start = 1'b1;
    din_v = with_sample;
    din   = 24'h123456;
    @(negedge clk);
    start = 1'b0;
    din_v = 1'b0;
    model_clear();
  endtask

  task automatic send(input logic [23:0] x, input logic [23:0] y);
    din   = x;
    din_v = 1'b1;
    push_exp(y);
    @(negedge clk);
    din_v = 1'b0;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL %s_drain: %0d outputs missing, expected 0", name, sb.size());
      sb.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic drive_ignored(input int n);
    valid_seen = 0;
    for (int i = 0; i < n; i++) begin
      din   = 24'(i * 7 + 3);
      din_v = 1'b1;
      @(negedge clk);
    end
    din_v = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  function automatic logic [23:0] imp_y(input int n);
    return (n < 22) ? 24'(1 << (22 - n)) : 24'd1;
  endfunction

  // Output monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (d_v[sel]) begin
      exp_t e;
      valid_seen++;
      if (done[sel]) done_seen++;
      if (stab[sel] && first_stable < 0) first_stable = int'(a[sel]);
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: got data %0h addr %0d, expected no output", d_out[sel], a[sel]);
      end else begin
        e = sb.pop_front();
        chk("data", 32'(d_out[sel]), 32'(e.data));
        chk("addr", 32'(a[sel]), 32'(e.addr));
        chk("done", 32'(done[sel]), 32'(e.done));
        chk("stable", 32'(stab[sel]), 32'(e.stable));
        chk("latency", 32'(cyc - e.acc_cyc), 32'd3);
      end
    end else if (done[sel]) begin
      checks++;
      errors++;
      $display("FAIL done_without_valid: got 1, expected 0");
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  initial begin
    sat_tab[0] = '{24'h7FFFFF, 24'h7FFFFF};
    sat_tab[1] = '{24'h800000, 24'h800000};
    sat_tab[2] = '{24'h000100, 24'h000400};
    sat_tab[3] = '{24'hFFFF00, 24'hFFFC00};
    sat_tab[4] = '{24'h000000, 24'h000000};

    rst_n = 1'b1; start = 1'b0; din_v = 1'b0; din = 24'h0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk("rst_data", 32'(d_out[i]), 32'd0);
      chk("rst_valid", 32'(d_v[i]), 32'd0);
      chk("rst_addr", 32'(a[i]), 32'd0);
      chk("rst_done", 32'(done[i]), 32'd0);
      chk("rst_stable", 32'(stab[i]), 32'd0);
    end
    rst_n = 1'b0;

    // Samples before any start are ignored.
    drive_ignored(10);
    chk("prestart_valid_count", 32'(valid_seen), 32'd0);

    // Full passthrough run.
    sel = 0; done_seen = 0;
    do_start(1'b1);
    for (int i = 0; i < 2048; i++) send(24'(i), 24'(i));
    drain("pass");
    chk("pass_done_count", 32'(done_seen), 32'd1);
    drive_ignored(6);
    chk("pass_disarmed_valid_count", 32'(valid_seen), 32'd0);

    // Impulse through a one-pole section, continuous then gapped.
    sel = 1;
    for (int g = 0; g < 2; g++) begin
      first_stable = -1; valid_seen = 0;
      do_start(1'b0);
      for (int i = 0; i < 40; i++) begin
        send((i == 0) ? 24'h400000 : 24'h000000, imp_y(i));
        if (g == 1) @(negedge clk);
      end
      drain(g == 0 ? "impulse" : "impulse_gapped");
      chk("imp_stable_rise_idx", 32'(first_stable), 32'd31);
      chk("imp_stable_hold", 32'(stab[1]), 32'd1);
      chk("imp_valid_count", 32'(valid_seen), 32'd40);
    end

    // Saturation vectors.
    sel = 2;
    do_start(1'b0);
    for (int i = 0; i < 5; i++) send(sat_tab[i].din, sat_tab[i].dexp);
    drain("sat");

    // Restart mid-run at sample 100: three in-flight samples are flushed.
    sel = 0; done_seen = 0;
    do_start(1'b0);
    for (int i = 0; i < 100; i++) send(24'(i + 500), 24'(i + 500));
    start = 1'b1; din_v = 1'b1; din = 24'h0ABCDE;
    repeat (3) void'(sb.pop_back());
    @(negedge clk);
    start = 1'b0; din_v = 1'b0;
    model_clear();
    for (int i = 0; i < 20; i++) send(24'(i * 3 + 9), 24'(i * 3 + 9));

    // Reset mid-run, together with start: reset wins.
    for (int i = 0; i < 10; i++) send(24'(i + 77), 24'(i + 77));
    rst_n = 1'b1; start = 1'b1; din_v = 1'b1; din = 24'h055555;
    repeat (3) void'(sb.pop_back());
    @(negedge clk);
    rst_n = 1'b0; start = 1'b0; din_v = 1'b0;
    chk("postrst_data", 32'(d_out[0]), 32'd0);
    chk("postrst_valid", 32'(d_v[0]), 32'd0);
    chk("postrst_addr", 32'(a[0]), 32'd0);
    chk("postrst_done", 32'(done[0]), 32'd0);
    chk("postrst_stable", 32'(stab[0]), 32'd0);
    drive_ignored(8);
    chk("postrst_disarmed_valid_count", 32'(valid_seen), 32'd0);
    chk("restart_done_count", 32'(done_seen), 32'd0);
    drain("final");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
